// File: rtl/booth_controller.sv
// ---------------------------------------------------------------------------
// booth_controller
//
// Control unit for a radix-2 Booth multiplier. Sequences an external
// A/Q/Q-1/M datapath through one multiplication: load the operands, then for
// REG_WIDTH iterations inspect {q0,q_1}, optionally add or subtract M into A,
// and arithmetic-shift A:Q:Q-1 right. When the iterations are exhausted, A:Q
// is copied to the result registers and a one-cycle done pulse is raised.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   begin a multiplication (honoured in IDLE only)
//   abort    in   cancel the operation in progress (any non-IDLE state)
//   q0       in   current LSB of the Q register
//   q_1      in   current Q-1 bit
//   load_a   out  A register write enable
//   load_q   out  load multiplier operand into Q
//   load_m   out  load multiplicand operand into M
//   clr_a    out  A input mux selects zero (only with load_a in LOAD)
//   clr_q1   out  clear the Q-1 flop
//   alu_add  out  ALU computes A+M
//   alu_sub  out  ALU computes A-M
//   shr      out  arithmetic shift right of A:Q:Q-1
//   dump     out  copy A:Q into the result registers
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse marking a valid result
//   count    out  remaining iterations
//
// REG_WIDTH is the operand width and iteration count; meaningful values are
// 2..64.
// ---------------------------------------------------------------------------
module booth_controller #(
  parameter int REG_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             q0,
  input  logic                             q_1,
  output logic                             load_a,
  output logic                             load_q,
  output logic                             load_m,
  output logic                             clr_a,
  output logic                             clr_q1,
  output logic                             alu_add,
  output logic                             alu_sub,
  output logic                             shr,
  output logic                             dump,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(REG_WIDTH+1)-1:0]   count
);

  localparam int CW = $clog2(REG_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    ADD,
    SUB,
    SHIFT,
    DUMP,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state and iteration-counter logic. Abort overrides every other
  // transition and also freezes the counter, so the aborted operation leaves
  // count at the value it had when it was cancelled.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = LOAD;
        end
        LOAD: begin
          count_d = CW'(REG_WIDTH);
          state_d = EVAL;
        end
        EVAL: begin
          case ({q0, q_1})
            2'b10:   state_d = SUB;
            2'b01:   state_d = ADD;
            default: state_d = SHIFT;
          endcase
        end
        ADD: state_d = SHIFT;
        SUB: state_d = SHIFT;
        SHIFT: begin
          // Saturate at zero; a zero count here also exits so the FSM can
          // never loop forever on a corrupted counter.
          if (count_q != '0) count_d = count_q - CW'(1);
          if (count_q <= CW'(1)) state_d = DUMP;
          else                   state_d = EVAL;
        end
        DUMP:    state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Moore output decode: strobes depend on the state register only.
  always_comb begin
    load_a  = 1'b0;
    load_q  = 1'b0;
    load_m  = 1'b0;
    clr_a   = 1'b0;
    clr_q1  = 1'b0;
    alu_add = 1'b0;
    alu_sub = 1'b0;
    shr     = 1'b0;
    dump    = 1'b0;
    done    = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      LOAD: begin
        load_a = 1'b1;
        clr_a  = 1'b1;
        load_q = 1'b1;
        load_m = 1'b1;
        clr_q1 = 1'b1;
      end
      ADD: begin
        alu_add = 1'b1;
        load_a  = 1'b1;
      end
      SUB: begin
        alu_sub = 1'b1;
        load_a  = 1'b1;
      end
      SHIFT:   shr  = 1'b1;
      DUMP:    dump = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign count = count_q;

endmodule

// File: tb/tb_booth_controller.sv
// ---------------------------------------------------------------------------
// tb_booth_controller
//
// Self-checking bench for booth_controller with REG_WIDTH=8. A behavioural
// A/Q/Q-1/M datapath reacts to the controller strobes and feeds q0/q_1 back,
// so real multiplications run end to end. For each operation the expected
// per-cycle strobe/count trace and the expected product are pushed to
// scoreboard queues when start is driven, then popped and compared cycle by
// cycle. q0/q_1 can also be forced to a constant pair for pure-FSM runs.
// ---------------------------------------------------------------------------
module tb_booth_controller;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  // Strobe vector bit order:
  // {load_a, load_q, load_m, clr_a, clr_q1, alu_add, alu_sub, shr, dump, busy, done}
  localparam logic [10:0] IDLE_V  = 11'b00000000000;
  localparam logic [10:0] LOAD_V  = 11'b11111000010;
  localparam logic [10:0] EVAL_V  = 11'b00000000010;
  localparam logic [10:0] ADD_V   = 11'b10000100010;
  localparam logic [10:0] SUB_V   = 11'b10000010010;
  localparam logic [10:0] SHIFT_V = 11'b00000001010;
  localparam logic [10:0] DUMP_V  = 11'b00000000110;
  localparam logic [10:0] DONE_V  = 11'b00000000011;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic q0;
  logic q_1;
  logic load_a, load_q, load_m, clr_a, clr_q1;
  logic alu_add, alu_sub, shr, dump, busy, done;
  logic [CW-1:0] count;

  booth_controller #(.REG_WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .q0      (q0),
    .q_1     (q_1),
    .load_a  (load_a),
    .load_q  (load_q),
    .load_m  (load_m),
    .clr_a   (clr_a),
    .clr_q1  (clr_q1),
    .alu_add (alu_add),
    .alu_sub (alu_sub),
    .shr     (shr),
    .dump    (dump),
    .busy    (busy),
    .done    (done),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath driven by the controller strobes
  logic [W-1:0]   a_reg, q_reg, m_reg, m_op, q_op;
  logic           qm1_reg;
  logic [2*W-1:0] result_reg;
  logic           forced_mode;
  logic [1:0]     forced_pair;

  always @(posedge clk) begin
    if (load_a)
      a_reg <= clr_a   ? '0 :
               alu_add ? a_reg + m_reg :
               alu_sub ? a_reg - m_reg : a_reg;
    if (load_q) q_reg   <= q_op;
    if (load_m) m_reg   <= m_op;
    if (clr_q1) qm1_reg <= 1'b0;
    if (shr) {a_reg, q_reg, qm1_reg} <= {a_reg[W-1], a_reg, q_reg};
    if (dump) result_reg <= {a_reg, q_reg};
  end

  assign q0  = forced_mode ? forced_pair[1] : q_reg[0];
  assign q_1 = forced_mode ? forced_pair[0] : qm1_reg;

  // Scoreboard
  typedef struct {
    logic [10:0] strobes;
    int          cnt;
  } exp_t;

  exp_t           trace_q[$];
  logic [2*W-1:0] prod_q[$];

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] prod;
  } vec_t;

  vec_t vecs[8];

  int n_checks;
  int n_fails;

  function automatic logic [10:0] out_vec();
    return {load_a, load_q, load_m, clr_a, clr_q1, alu_add, alu_sub, shr, dump, busy, done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] m_in, input logic [W-1:0] q_in,
                               input bit forced, input logic [1:0] pair_in);
    m_op        = m_in;
    q_op        = q_in;
    forced_mode = forced;
    forced_pair = pair_in;
    start       = 1'b1;
  endtask

  task automatic push_exp(input logic [10:0] s, input int c);
    exp_t e;
    e.strobes = s;
    e.cnt     = c;
    trace_q.push_back(e);
  endtask

  // Runs one full operation starting from an IDLE cycle. The expected trace
  // is derived from the operand bits (or the forced pair) independently.
  task automatic runOp(input logic [W-1:0] m_in, input logic [W-1:0] q_in,
                       input logic [2*W-1:0] exp_prod, input bit forced,
                       input logic [1:0] pair_in, input int prev_count,
                       input bit hold_start, input bit check_prod, input string tag);
    logic [1:0] pr;
    logic       prev_bit;
    exp_t       e;
    logic [2*W-1:0] p;
    prev_bit = 1'b0;
    push_exp(LOAD_V, prev_count);
    for (int i = 0; i < W; i++) begin
      pr = forced ? pair_in : {q_in[i], prev_bit};
      prev_bit = q_in[i];
      push_exp(EVAL_V, W - i);
      if (pr == 2'b10)      push_exp(SUB_V, W - i);
      else if (pr == 2'b01) push_exp(ADD_V, W - i);
      push_exp(SHIFT_V, W - i);
    end
    push_exp(DUMP_V, 0);
    push_exp(DONE_V, 0);
    push_exp(IDLE_V, 0);
    if (check_prod) prod_q.push_back(exp_prod);
    applyStimulus(m_in, q_in, forced, pair_in);
    while (trace_q.size() > 0) begin
      step();
      if (!hold_start) start = 1'b0;
      e = trace_q.pop_front();
      checkOutput({tag, " strobes"}, 32'(out_vec()), 32'(e.strobes));
      checkOutput({tag, " count"}, 32'(count), 32'(e.cnt));
      if (e.strobes == DONE_V && check_prod) begin
        if (prod_q.size() == 0) begin
          checkOutput({tag, " product queue empty"}, 32'd1, 32'd0);
        end else begin
          p = prod_q.pop_front();
          checkOutput({tag, " product"}, 32'(result_reg), 32'(p));
        end
      end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    forced_mode = 1'b0;
    forced_pair = 2'b00;
    m_op        = '0;
    q_op        = '0;

    vecs[0] = '{m: 8'h03, q: 8'hFC, prod: 16'hFFF4};
    vecs[1] = '{m: 8'hF9, q: 8'h05, prod: 16'hFFDD};
    vecs[2] = '{m: 8'h05, q: 8'h00, prod: 16'h0000};
    vecs[3] = '{m: 8'h05, q: 8'h06, prod: 16'h001E};
    vecs[4] = '{m: 8'hF8, q: 8'h07, prod: 16'hFFC8};
    vecs[5] = '{m: 8'h7F, q: 8'hFF, prod: 16'hFF81};
    vecs[6] = '{m: 8'hFF, q: 8'hFF, prod: 16'h0001};
    vecs[7] = '{m: 8'h55, q: 8'hAA, prod: 16'hE372};

    // Reset state
    step();
    step();
    checkOutput("reset strobes", 32'(out_vec()), 32'(IDLE_V));
    checkOutput("reset count", 32'(count), 32'd0);
    rst_n = 1'b1;
    step();
    checkOutput("idle without start", 32'(out_vec()), 32'(IDLE_V));

    // Table of real multiplications through the datapath model
    for (int v = 0; v < 8; v++)
      runOp(vecs[v].m, vecs[v].q, vecs[v].prod, 1'b0, 2'b00, 0, 1'b0, 1'b1,
            $sformatf("vec%0d", v));

    // {q0,q_1}=10 held: SUB every iteration, done at cycle 27
    runOp('0, '0, '0, 1'b1, 2'b10, 0, 1'b0, 1'b0, "forced10");

    // Abort in the 4th SHIFT (cycle 9, count 5)
    applyStimulus(8'h05, 8'h00, 1'b1, 2'b00);
    step();
    start = 1'b0;
    for (int c = 2; c <= 9; c++) step();
    checkOutput("abort pre shift", 32'(out_vec()), 32'(SHIFT_V));
    checkOutput("abort pre count", 32'(count), 32'd5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort idle", 32'(out_vec()), 32'(IDLE_V));
    checkOutput("abort count frozen", 32'(count), 32'd5);
    step();
    checkOutput("abort idle hold", 32'(out_vec()), 32'(IDLE_V));
    checkOutput("abort count hold", 32'(count), 32'd5);
    runOp(8'h05, 8'h06, 16'h001E, 1'b0, 2'b00, 5, 1'b0, 1'b1, "after_abort");

    // Abort in DUMP beats DUMP->DONE
    applyStimulus(8'h00, 8'h00, 1'b1, 2'b00);
    step();
    start = 1'b0;
    for (int c = 2; c <= 18; c++) step();
    checkOutput("dump abort pre", 32'(out_vec()), 32'(DUMP_V));
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("dump abort idle", 32'(out_vec()), 32'(IDLE_V));
    step();
    checkOutput("dump abort no done", 32'(out_vec()), 32'(IDLE_V));

    // start held high: back-to-back, second LOAD after the IDLE following DONE
    runOp(8'h03, 8'hFC, 16'hFFF4, 1'b0, 2'b00, 0, 1'b1, 1'b1, "b2b_first");
    runOp(8'hF9, 8'h05, 16'hFFDD, 1'b0, 2'b00, 0, 1'b0, 1'b1, "b2b_second");

    // Reset during ADD with start held high
    applyStimulus(8'h00, 8'h00, 1'b1, 2'b01);
    step();
    start = 1'b0;
    step();
    checkOutput("rst eval", 32'(out_vec()), 32'(EVAL_V));
    step();
    checkOutput("rst add", 32'(out_vec()), 32'(ADD_V));
    rst_n = 1'b0;
    start = 1'b1;
    step();
    checkOutput("rst in add strobes", 32'(out_vec()), 32'(IDLE_V));
    checkOutput("rst in add count", 32'(count), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    step();
    checkOutput("rst after idle", 32'(out_vec()), 32'(IDLE_V));
    checkOutput("rst after count", 32'(count), 32'd0);

    // Clean operation after reset
    runOp(vecs[7].m, vecs[7].q, vecs[7].prod, 1'b0, 2'b00, 0, 1'b0, 1'b1, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/booth_controller.md
BOOTH_CONTROLLER -- requirements
Module: booth_controller

Interface
REQ-001 Parameter REG_WIDTH, default 8: operand width and iteration count; legal range 2..64.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 start  in  1  request to begin one multiplication; sampled only in IDLE.
REQ-005 abort  in  1  cancel the operation in progress; sampled in every non-IDLE state.
REQ-006 q0  in  1  current LSB of the Q (multiplier) register.
REQ-007 q_1  in  1  current Q-1 bit (last bit shifted out of Q).
REQ-008 load_a  out  1  write enable of the A register.
REQ-009 load_q  out  1  load multiplier operand into the Q register.
REQ-010 load_m  out  1  load multiplicand operand into the M register.
REQ-011 clr_a  out  1  A input mux selects zero; high only together with load_a in LOAD.
REQ-012 clr_q1  out  1  clear the Q-1 flop.
REQ-013 alu_add  out  1  ALU computes A+M.
REQ-014 alu_sub  out  1  ALU computes A-M.
REQ-015 shr  out  1  arithmetic shift right of the chained A:Q:Q-1 registers.
REQ-016 dump  out  1  copy A:Q into the result output registers.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse marking a valid result.
REQ-019 count  out  $clog2(REG_WIDTH+1)  remaining iterations.

Function
REQ-020 The FSM SHALL have exactly these states: IDLE, LOAD, EVAL, ADD, SUB, SHIFT, DUMP, DONE.
REQ-021 All outputs except count SHALL be decoded from the state register only (Moore) and SHALL be valid for the whole cycle in which the state is current.
REQ-022 IDLE: all strobes are low; start=1 moves the FSM to LOAD; start=0 keeps it in IDLE.
REQ-023 LOAD: load_a, clr_a, load_q, load_m and clr_q1 are high for exactly one cycle; count is set to REG_WIDTH; next state is EVAL.
REQ-024 EVAL: no strobes; {q0,q_1}=10 goes to SUB, 01 goes to ADD, 00 or 11 goes to SHIFT.
REQ-025 ADD: alu_add and load_a are high for one cycle; next state is SHIFT.
REQ-026 SUB: alu_sub and load_a are high for one cycle; next state is SHIFT.
REQ-027 alu_add and alu_sub SHALL never be high in the same cycle.
REQ-028 SHIFT: shr is high for one cycle; count decrements by 1 at the end of the cycle; if count==1 during SHIFT the next state is DUMP, otherwise EVAL.
REQ-029 count SHALL never wrap below 0; it holds its value in every state except LOAD and SHIFT.
REQ-030 DUMP: dump is high for one cycle; next state is DONE.
REQ-031 DONE: done is high for one cycle; next state is IDLE, regardless of start.
REQ-032 A start asserted in DONE or in any busy state SHALL be ignored; a new start is honoured only in IDLE.
REQ-033 abort=1 in any non-IDLE state SHALL force IDLE on the next edge; dump and done are not asserted for that operation.
REQ-034 abort takes priority over all other transitions, including DUMP→DONE and DONE→IDLE.
REQ-035 Latency from the start edge to the done cycle SHALL be 3 + sum over iterations of 2 (no op) or 3 (ADD/SUB) cycles.

Reset
REQ-036 rst_n=0 at a rising edge SHALL put the FSM in IDLE, set count to 0 and drive every strobe, busy and done low from the next cycle.
REQ-037 Reset has priority over start and abort.
REQ-038 Reset asserted mid-operation SHALL discard the operation with no dump or done pulse.

Verification
REQ-039 REG_WIDTH=8, start pulse at cycle 0, {q0,q_1}=00 held → LOAD at cycle 1, 8 EVAL/SHIFT pairs at cycles 2-17, dump at cycle 18, done at cycle 19, busy low at cycle 20.
REQ-040 REG_WIDTH=8, {q0,q_1}=10 held → SUB in every iteration, alu_add never high, 8 shr pulses, done at cycle 27.
REQ-041 REG_WIDTH=8, bench models A/Q/M with M=3, Q=-4 → dumped A:Q equals 16'hFFF4 (-12); repeat with M=-7, Q=5 → 16'hFFDD (-35).
REQ-042 abort asserted in the 4th SHIFT state → IDLE next cycle, count frozen at its value, no dump or done; a start 1 cycle later begins a clean LOAD.
REQ-043 start held high continuously → back-to-back operations; start is ignored while busy, and the second LOAD occurs exactly 1 cycle after DONE.
REQ-044 rst_n low for 1 cycle during ADD → IDLE next cycle, count=0, all strobes low; start held high during reset is ignored.
